// File: rtl/store_merge_unit.sv
// store_merge_unit: writes a word, halfword or byte into a 32-bit word-addressed data memory.
// Sub-word stores read the word, replace the addressed lane(s) and write it back.
// Ports:
//   clock, reset              rising-edge clock, synchronous active-high reset
//   req_valid/req_ready       store request handshake (ready only while idle)
//   req_addr/req_data/req_size byte address, right-justified data, size (0 W, 1 H, 2 B, 3 = W)
//   busy, done, misaligned    request in flight, one-cycle completion, halfword at odd address
//   mem_addr                  word address of the request in flight
//   mem_rd_en/mem_rdata       read strobe and read data (READ_LATENCY cycles later)
//   mem_wr_en/mem_wdata       full-word write strobe and data
module store_merge_unit #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic              busy,
    output logic              done,
    output logic              misaligned,
    output logic [ADDR_W-3:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [31:0]       mem_rdata,
    output logic              mem_wr_en,
    output logic [31:0]       mem_wdata
);

    localparam int unsigned CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_BYTE = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept;
    logic              merge_en;
    logic              misalign_d;
    logic [1:0]        lane_q;
    logic              is_byte_q;
    logic [15:0]       data_q;
    logic [31:0]       merged;

    // Next-state and control decode
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        merge_en   = 1'b0;
        misalign_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    accept = 1'b1;
                    case (req_size)
                        SZ_HALF: begin
                            if (req_addr[0]) begin
                                state_d    = S_RESP;
                                misalign_d = 1'b1;
                            end else begin
                                state_d = S_READ;
                            end
                        end
                        SZ_BYTE: state_d = S_READ;
                        default: state_d = S_WRITE;
                    endcase
                end
            end
            S_READ: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                // Read data is valid in the last wait cycle; merge it on leaving
                if (cnt_q == CNT_W'(READ_LATENCY - 1)) begin
                    merge_en = 1'b1;
                    state_d  = S_WRITE;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WRITE: state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Little-endian lane replacement over the word just read
    always_comb begin
        merged = mem_rdata;
        if (is_byte_q) begin
            merged[{lane_q, 3'b000} +: 8] = data_q[7:0];
        end else if (lane_q[1]) begin
            merged[31:16] = data_q;
        end else begin
            merged[15:0] = data_q;
        end
    end

    // State, request latches and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            lane_q     <= '0;
            is_byte_q  <= 1'b0;
            data_q     <= '0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            misaligned <= 1'b0;
            mem_addr   <= '0;
            mem_rd_en  <= 1'b0;
            mem_wr_en  <= 1'b0;
            mem_wdata  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                lane_q    <= req_addr[1:0];
                is_byte_q <= (req_size == SZ_BYTE);
                data_q    <= req_data[15:0];
            end
            if (accept && (state_d == S_WRITE)) begin
                mem_wdata <= req_data;
            end else if (merge_en) begin
                mem_wdata <= merged;
            end
            if (state_d == S_IDLE) begin
                mem_addr <= '0;
            end else if (accept) begin
                mem_addr <= req_addr[ADDR_W-1:2];
            end
            req_ready  <= (state_d == S_IDLE);
            busy       <= (state_d != S_IDLE);
            done       <= (state_d == S_RESP);
            misaligned <= misalign_d;
            mem_rd_en  <= (state_d == S_READ);
            mem_wr_en  <= (state_d == S_WRITE);
        end
    end

endmodule

// File: tb/tb_store_merge_unit.sv
// Testbench for store_merge_unit: two instances (READ_LATENCY 1 and 3), each with a small
// behavioural memory, checked against a byte-array reference model of the store rules.
module tb_store_merge_unit;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        vld   [2];
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic        rdy   [2];
    logic        bsy   [2];
    logic        dn    [2];
    logic        mis   [2];
    logic        rd    [2];
    logic        wr    [2];
    logic [29:0] maddr [2];
    logic [31:0] wd    [2];
    logic [31:0] rdat  [2];

    int errors = 0;
    int checks = 0;
    int acc [2];

    store_merge_unit #(.ADDR_W(32), .READ_LATENCY(1)) dut1 (
        .clock(clock), .reset(reset), .req_valid(vld[0]), .req_ready(rdy[0]),
        .req_addr(addr), .req_data(data), .req_size(size), .busy(bsy[0]), .done(dn[0]),
        .misaligned(mis[0]), .mem_addr(maddr[0]), .mem_rd_en(rd[0]), .mem_rdata(rdat[0]),
        .mem_wr_en(wr[0]), .mem_wdata(wd[0]));

    store_merge_unit #(.ADDR_W(32), .READ_LATENCY(3)) dut3 (
        .clock(clock), .reset(reset), .req_valid(vld[1]), .req_ready(rdy[1]),
        .req_addr(addr), .req_data(data), .req_size(size), .busy(bsy[1]), .done(dn[1]),
        .misaligned(mis[1]), .mem_addr(maddr[1]), .mem_rd_en(rd[1]), .mem_rdata(rdat[1]),
        .mem_wr_en(wr[1]), .mem_wdata(wd[1]));

    // Memories: read data is valid only in the single cycle READ_LATENCY after the strobe
    logic        pl_en0, pl_en1;
    logic [5:0]  pl_a;
    logic [31:0] pl_d;
    logic [31:0] mem0 [64];
    logic [31:0] mem1 [64];
    logic [31:0] ref0 [64];
    logic [31:0] ref1 [64];
    logic        v0;
    logic [31:0] d0;
    logic [2:0]  v1;
    logic [31:0] d1 [3];

    always @(posedge clock) begin
        if (pl_en0) mem0[pl_a] <= pl_d;
        else if (wr[0]) mem0[maddr[0][5:0]] <= wd[0];
        v0 <= rd[0];
        d0 <= mem0[maddr[0][5:0]];
    end
    assign rdat[0] = v0 ? d0 : 32'hA5A5_5A5A;

    always @(posedge clock) begin
        if (pl_en1) mem1[pl_a] <= pl_d;
        else if (wr[1]) mem1[maddr[1][5:0]] <= wd[1];
        v1    <= {v1[1:0], rd[1]};
        d1[0] <= mem1[maddr[1][5:0]];
        d1[1] <= d1[0];
        d1[2] <= d1[1];
    end
    assign rdat[1] = v1[2] ? d1[2] : 32'h5A5A_A5A5;

    always @(posedge clock) begin
        if (!reset && vld[0] && rdy[0]) acc[0] <= acc[0] + 1;
        if (!reset && vld[1] && rdy[1]) acc[1] <= acc[1] + 1;
    end

    // Reference: memory word as four bytes, overwrite the addressed ones
    function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] a,
                                                input logic [31:0] d, input logic [1:0] sz);
        logic [7:0]  b [4];
        logic [31:0] r;
        int          off;
        off = int'(a % 4);
        for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
        if (sz == 2'd2) begin
            b[off] = d[7:0];
        end else if (sz == 2'd1) begin
            b[off]     = d[7:0];
            b[off + 1] = d[15:8];
        end else begin
            for (int i = 0; i < 4; i++) b[i] = d[8*i +: 8];
        end
        for (int i = 0; i < 4; i++) r[8*i +: 8] = b[i];
        return r;
    endfunction

    function automatic bit model_misaligned(input logic [31:0] a, input logic [1:0] sz);
        return (sz == 2'd1) && ((a % 2) == 1);
    endfunction

    function automatic bit model_subword(input logic [1:0] sz);
        return (sz == 2'd1) || (sz == 2'd2);
    endfunction

    task automatic set_word(input int s, input int idx, input logic [31:0] val);
        @(negedge clock);
        pl_en0 = (s == 0);
        pl_en1 = (s == 1);
        pl_a   = 6'(idx);
        pl_d   = val;
        if (s == 0) ref0[idx] = val; else ref1[idx] = val;
        @(negedge clock);
        pl_en0 = 1'b0;
        pl_en1 = 1'b0;
    endtask

    // Issue one store and record what the memory port and response did, cycle-indexed
    // from the accept edge (k=1 is the cycle right after it)
    task automatic run_store(input int s, input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] sz, input bit hold,
                             output int rd_k, output int wr_k, output int done_k,
                             output int rd_n, output int wr_n, output logic mis_d,
                             output logic [31:0] wd_w, output logic [29:0] ma_w,
                             output bit mis_bad);
        rd_k = -1; wr_k = -1; done_k = -1; rd_n = 0; wr_n = 0;
        mis_d = 1'b0; wd_w = '0; ma_w = '0; mis_bad = 1'b0;
        @(negedge clock);
        addr = a; data = d; size = sz; vld[s] = 1'b1;
        @(posedge clock);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (k == 1) begin
                if (!hold) vld[s] = 1'b0;
                addr = $urandom; data = $urandom; size = 2'($urandom);
            end
            if (rd[s]) begin rd_n++; rd_k = k; end
            if (wr[s]) begin wr_n++; wr_k = k; wd_w = wd[s]; ma_w = maddr[s]; end
            if (mis[s] && !dn[s]) mis_bad = 1'b1;
            if (dn[s]) begin done_k = k; mis_d = mis[s]; break; end
        end
        vld[s] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        for (int s = 0; s < 2; s++) begin
            checks++; if (rdy[s] !== 1'b1) begin errors++; $display("FAIL reset_ready[%0d]: got %b want 1", s, rdy[s]); end
            checks++;
            if ({bsy[s], dn[s], mis[s], rd[s], wr[s]} !== 5'b0) begin
                errors++; $display("FAIL reset_flags[%0d]: got %b want 00000", s, {bsy[s], dn[s], mis[s], rd[s], wr[s]});
            end
            checks++;
            if (maddr[s] !== 30'd0 || wd[s] !== 32'd0) begin
                errors++; $display("FAIL reset_mem_port[%0d]: got addr %h data %h want 0 0", s, maddr[s], wd[s]);
            end
        end
    endtask

    task automatic test_word();
        int rk, wk, dk, rn, wn; logic md; logic [31:0] w; logic [29:0] m; bit mb;
        logic [31:0] exp_w; logic [31:0] d3;
        exp_w = model_store(ref0[4], 32'h10, 32'hDEADBEEF, 2'd0);
        run_store(0, 32'h0000_0010, 32'hDEADBEEF, 2'd0, 1'b0, rk, wk, dk, rn, wn, md, w, m, mb);
        ref0[4] = exp_w;
        checks++; if (wk !== 1 || wn !== 1) begin errors++; $display("FAIL word_write_cycle: got k=%0d n=%0d want k=1 n=1", wk, wn); end
        checks++; if (dk !== 2) begin errors++; $display("FAIL word_done_cycle: got %0d want 2", dk); end
        checks++; if (rn !== 0) begin errors++; $display("FAIL word_no_read: got %0d reads want 0", rn); end
        checks++; if (w !== 32'hDEADBEEF || w !== exp_w) begin errors++; $display("FAIL word_wdata: got %h want %h", w, exp_w); end
        checks++; if (m !== 30'h4) begin errors++; $display("FAIL word_addr: got %h want 4", m); end
        checks++; if (md !== 1'b0 || mb) begin errors++; $display("FAIL word_misaligned: got %b/%b want 0/0", md, mb); end
        // Reserved size behaves as a word store and ignores the low address bits
        d3 = $urandom;
        exp_w = model_store(ref0[8], 32'h20, d3, 2'd0);
        run_store(0, 32'h0000_0023, d3, 2'd3, 1'b0, rk, wk, dk, rn, wn, md, w, m, mb);
        ref0[8] = exp_w;
        checks++;
        if (w !== exp_w || m !== 30'h8 || wk !== 1 || dk !== 2 || rn !== 0) begin
            errors++; $display("FAIL reserved_word: got data %h addr %h wr %0d done %0d rd %0d want %h 8 1 2 0", w, m, wk, dk, rn, exp_w);
        end
    endtask

    task automatic test_byte_lanes();
        int rk, wk, dk, rn, wn; logic md; logic [31:0] w; logic [29:0] m; bit mb;
        logic [31:0] exp_tab [4];
        logic [31:0] d;
        exp_tab = '{32'h112233AB, 32'h1122AB44, 32'h11AB3344, 32'hAB223344};
        for (int off = 0; off < 4; off++) begin
            set_word(0, 5, 32'h11223344);
            d = {24'($urandom), 8'hAB};
            run_store(0, 32'h14 + 32'(off), d, 2'd2, 1'b0, rk, wk, dk, rn, wn, md, w, m, mb);
            ref0[5] = model_store(32'h11223344, 32'h14 + 32'(off), d, 2'd2);
            checks++; if (w !== exp_tab[off]) begin errors++; $display("FAIL byte_lane%0d_wdata: got %h want %h", off, w, exp_tab[off]); end
            checks++;
            if (rk !== 1 || wk !== 3 || dk !== 4 || rn !== 1 || wn !== 1 || m !== 30'h5) begin
                errors++; $display("FAIL byte_lane%0d_timing: got rd %0d wr %0d done %0d n %0d/%0d addr %h want 1 3 4 1/1 5", off, rk, wk, dk, rn, wn, m);
            end
        end
    endtask

    task automatic test_halfword();
        int rk, wk, dk, rn, wn; logic md; logic [31:0] w; logic [29:0] m; bit mb;
        logic [31:0] exp_tab [2];
        int offs [2];
        exp_tab = '{32'hCAFE3344, 32'h1122CAFE};
        offs    = '{2, 0};
        for (int i = 0; i < 2; i++) begin
            set_word(0, 6, 32'h11223344);
            run_store(0, 32'h18 + 32'(offs[i]), 32'h0000CAFE, 2'd1, 1'b0, rk, wk, dk, rn, wn, md, w, m, mb);
            ref0[6] = exp_tab[i];
            checks++; if (w !== exp_tab[i]) begin errors++; $display("FAIL half_off%0d_wdata: got %h want %h", offs[i], w, exp_tab[i]); end
            checks++;
            if (dk !== 4 || wk !== 3 || md !== 1'b0 || mb) begin
                errors++; $display("FAIL half_off%0d_timing: got wr %0d done %0d mis %b want 3 4 0", offs[i], wk, dk, md);
            end
        end
    endtask

    task automatic test_misaligned();
        int rk, wk, dk, rn, wn; logic md; logic [31:0] w; logic [29:0] m; bit mb;
        int offs [2];
        offs = '{1, 3};
        for (int i = 0; i < 2; i++) begin
            run_store(0, 32'h30 + 32'(offs[i]), $urandom, 2'd1, 1'b0, rk, wk, dk, rn, wn, md, w, m, mb);
            checks++; if (dk !== 1 || md !== 1'b1) begin errors++; $display("FAIL misaligned%0d_resp: got done %0d mis %b want 1 1", offs[i], dk, md); end
            checks++; if (rn !== 0 || wn !== 0) begin errors++; $display("FAIL misaligned%0d_strobes: got rd %0d wr %0d want 0 0", offs[i], rn, wn); end
            @(negedge clock);
            checks++; if (rdy[0] !== 1'b1 || mis[0] !== 1'b0) begin errors++; $display("FAIL misaligned%0d_ready: got rdy %b mis %b want 1 0", offs[i], rdy[0], mis[0]); end
            checks++; if (mem0[12] !== ref0[12]) begin errors++; $display("FAIL misaligned%0d_mem: got %h want %h", offs[i], mem0[12], ref0[12]); end
        end
    endtask

    task automatic test_reset_midop();
        int wn;
        wn = 0;
        @(negedge clock);
        addr = 32'h41; data = 32'h0000_00EE; size = 2'd2; vld[0] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        vld[0] = 1'b0;
        @(negedge clock);
        checks++; if (bsy[0] !== 1'b1 || rd[0] !== 1'b0) begin errors++; $display("FAIL rst_mid_wait: got busy %b rd %b want 1 0", bsy[0], rd[0]); end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (rdy[0] !== 1'b1 || bsy[0] !== 1'b0 || wr[0] !== 1'b0 || dn[0] !== 1'b0) begin
            errors++; $display("FAIL rst_mid_idle: got rdy %b busy %b wr %b done %b want 1 0 0 0", rdy[0], bsy[0], wr[0], dn[0]);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (wr[0] || dn[0]) wn++;
        end
        checks++; if (wn !== 0) begin errors++; $display("FAIL rst_mid_no_write: got %0d strobes want 0", wn); end
        checks++; if (mem0[16] !== ref0[16]) begin errors++; $display("FAIL rst_mid_mem: got %h want %h", mem0[16], ref0[16]); end
    endtask

    task automatic test_latency();
        int rk, wk, dk, rn, wn; logic md; logic [31:0] w; logic [29:0] m; bit mb;
        logic [31:0] exp_w; logic [31:0] d; int a0;
        d = $urandom;
        exp_w = model_store(ref1[9], 32'h26, d, 2'd2);
        a0 = acc[1];
        run_store(1, 32'h26, d, 2'd2, 1'b1, rk, wk, dk, rn, wn, md, w, m, mb);
        ref1[9] = exp_w;
        @(negedge clock);
        checks++; if (w !== exp_w) begin errors++; $display("FAIL lat3_wdata: got %h want %h", w, exp_w); end
        checks++;
        if (rk !== 1 || wk !== 5 || dk !== 6 || rn !== 1 || wn !== 1) begin
            errors++; $display("FAIL lat3_timing: got rd %0d wr %0d done %0d n %0d/%0d want 1 5 6 1/1", rk, wk, dk, rn, wn);
        end
        checks++; if (acc[1] - a0 !== 1) begin errors++; $display("FAIL lat3_single_accept: got %0d accepts want 1", acc[1] - a0); end
    endtask

    task automatic test_random();
        int rk, wk, dk, rn, wn; logic md; logic [31:0] w; logic [29:0] m; bit mb;
        logic [31:0] a, d, exp_w; logic [1:0] sz; int s, idx, lat, exp_wk;
        bit bad;
        for (int n = 0; n < 40; n++) begin
            s   = (n % 4 == 3) ? 1 : 0;
            lat = (s == 0) ? 1 : 3;
            a   = 32'($urandom_range(0, 255));
            d   = $urandom;
            sz  = 2'($urandom);
            idx = int'(a / 4);
            exp_w = model_store((s == 0) ? ref0[idx] : ref1[idx], a, d, sz);
            run_store(s, a, d, sz, n[0], rk, wk, dk, rn, wn, md, w, m, mb);
            bad = 1'b0;
            if (model_misaligned(a, sz)) begin
                if (dk !== 1 || md !== 1'b1 || rn !== 0 || wn !== 0) bad = 1'b1;
            end else begin
                exp_wk = model_subword(sz) ? 2 + lat : 1;
                if (wk !== exp_wk || dk !== exp_wk + 1 || wn !== 1 || md !== 1'b0) bad = 1'b1;
                if (rn !== (model_subword(sz) ? 1 : 0)) bad = 1'b1;
                if (w !== exp_w || m !== 30'(a / 4)) bad = 1'b1;
                if (s == 0) ref0[idx] = exp_w; else ref1[idx] = exp_w;
            end
            checks++;
            if (bad || mb) begin
                errors++;
                $display("FAIL random%0d inst%0d a=%h sz=%0d: got wr %0d done %0d mis %b data %h addr %h want data %h addr %h",
                         n, s, a, sz, wk, dk, md, w, m, exp_w, 30'(a / 4));
            end
        end
    endtask

    task automatic test_final_memory();
        int bad0, bad1;
        bad0 = 0; bad1 = 0;
        @(negedge clock);
        for (int i = 0; i < 64; i++) begin
            if (mem0[i] !== ref0[i]) bad0++;
            if (mem1[i] !== ref1[i]) bad1++;
        end
        checks++; if (bad0 !== 0) begin errors++; $display("FAIL final_mem0: got %0d differing words want 0", bad0); end
        checks++; if (bad1 !== 0) begin errors++; $display("FAIL final_mem1: got %0d differing words want 0", bad1); end
    endtask

    initial begin
        reset = 1'b1;
        vld[0] = 1'b0; vld[1] = 1'b0;
        addr = '0; data = '0; size = '0;
        pl_en0 = 1'b0; pl_en1 = 1'b0; pl_a = '0; pl_d = '0;
        for (int i = 0; i < 64; i++) begin
            set_word(0, i, $urandom);
            set_word(1, i, $urandom);
        end
        test_reset();
        test_word();
        test_byte_lanes();
        test_halfword();
        test_misaligned();
        test_reset_midop();
        test_latency();
        test_random();
        test_final_memory();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
